fifo_byte_packer: RTL

//  Capture front-end directly upstream of the 16-bit sync FIFO. Gates an 8-bit sample stream with arm/trigger.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_byte_packer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-packing capture front-end and its FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: capture FSM state encoding, FIFO data width, default pad byte.
package fifo_pkg;

   // Width of one FIFO word; two sample bytes are packed per word.
   localparam int FIFO_DW = 16;

   // Filler for the upper byte of a final word when the capture length is odd.
   localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage : fifo_pkg

// File: rtl/fifo_byte_packer.sv
// Arm/trigger-gated capture of an 8-bit sample stream, packed little-endian into 16-bit FIFO writes.
// Latency: a word is presented on wen/wdata the cycle after its completing byte is consumed.
// Backpressure: none upstream; a word whose write coincides with fifo_full is dropped and drop_err is set.
//
// Ports:
//   clk          in   single clock, shared with the FIFO
//   reset        in   synchronous, active-high
//   arm          in   1-cycle pulse, accepted only in IDLE/DONE; latches capture_len, clears loss status
//   trigger      in   level, sampled only while ARMED
//   capture_len  in   number of bytes to capture
//   byte_valid   in   byte_data valid this cycle
//   byte_data    in   sample byte
//   fifo_full    in   FIFO full flag, gates the write-enable register input
//   wen / wdata  out  registered FIFO write port
//   busy         out  state is ARMED, CAPTURE or FLUSH
//   done         out  1-cycle pulse on entry to DONE
//   drop_err     out  sticky: at least one word was dropped since the last arm
//   bytes_left   out  bytes still to be consumed in the current capture
//   drop_count   out  (only with FIFO_PACKER_STATS_EN) saturating count of dropped words since arm
module fifo_byte_packer
   import fifo_pkg::*;
#(
   parameter int         pLEN_WIDTH = 16,
   parameter logic [7:0] pPAD_BYTE  = PAD_BYTE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  trigger,
   input  logic [pLEN_WIDTH-1:0] capture_len,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   input  logic                  fifo_full,
   output logic                  wen,
   output logic [FIFO_DW-1:0]    wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  drop_err,
`ifdef FIFO_PACKER_STATS_EN
   output logic [15:0]           drop_count,
`endif
   output logic [pLEN_WIDTH-1:0] bytes_left
);

   state_t                r_state;
   logic [pLEN_WIDTH-1:0] r_bytes_left;
   logic                  r_done;
   logic                  r_wen;
   logic [FIFO_DW-1:0]    r_wdata;
   logic                  r_drop_err;
   logic                  r_hold;       // low byte of the current word is waiting in r_held
   logic [7:0]            r_held;
`ifdef FIFO_PACKER_STATS_EN
   logic [15:0]           r_drop_count;
`endif

   logic                  w_arm_ok;
   logic                  w_trig_start;
   logic                  w_consume;
   logic                  w_last;
   logic                  w_issue;
   logic                  w_drop;
   logic [FIFO_DW-1:0]    w_word;

   assign w_arm_ok     = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_trig_start = (r_state == ST_ARMED) && trigger;

   // A byte arriving in the very cycle the trigger is first seen is part of the capture.
   // The bytes_left guard also keeps a zero-length capture from consuming anything.
   assign w_consume = byte_valid && (r_bytes_left != '0)
                      && ((r_state == ST_CAPTURE) || w_trig_start);
   assign w_last    = w_consume && (r_bytes_left == pLEN_WIDTH'(1));

   // A word completes on the second byte of a pair, or on a lone final byte, which is
   // padded right away so the last write always lands in the FLUSH cycle.
   assign w_issue = w_consume && (r_hold || w_last);
   assign w_word  = r_hold ? {byte_data, r_held} : {pPAD_BYTE, byte_data};
   assign w_drop  = w_issue && fifo_full;

   // Capture FSM and byte accounting.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_bytes_left <= '0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_arm_ok) begin
                  r_state      <= ST_ARMED;
                  r_bytes_left <= capture_len;
               end
            end
            ST_ARMED: begin
               if (trigger) begin
                  if (r_bytes_left == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else if (w_last) begin
                     r_state <= ST_FLUSH;
                  end else begin
                     r_state <= ST_CAPTURE;
                  end
               end
            end
            ST_CAPTURE: begin
               if (w_last) begin
                  r_state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               r_state <= ST_DONE;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
         // w_consume already implies r_bytes_left != 0, so this never wraps.
         if (w_consume) begin
            r_bytes_left <= r_bytes_left - pLEN_WIDTH'(1);
         end
      end
   end

   // Packing register, FIFO write port and loss reporting.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wen      <= 1'b0;
         r_wdata    <= '0;
         r_hold     <= 1'b0;
         r_held     <= 8'h00;
         r_drop_err <= 1'b0;
`ifdef FIFO_PACKER_STATS_EN
         r_drop_count <= 16'h0000;
`endif
      end else begin
         // fifo_full is folded in ahead of the register so a dropped word never reaches the FIFO.
         r_wen <= w_issue && !fifo_full;
         if (w_issue && !fifo_full) begin
            r_wdata <= w_word;
         end

         if (w_arm_ok) begin
            r_hold     <= 1'b0;
            r_drop_err <= 1'b0;
`ifdef FIFO_PACKER_STATS_EN
            r_drop_count <= 16'h0000;
`endif
         end else begin
            if (w_consume) begin
               if (w_issue) begin
                  r_hold <= 1'b0;
               end else begin
                  r_hold <= 1'b1;
                  r_held <= byte_data;
               end
            end
            if (w_drop) begin
               r_drop_err <= 1'b1;
`ifdef FIFO_PACKER_STATS_EN
               if (r_drop_count != 16'hFFFF) begin
                  r_drop_count <= r_drop_count + 16'h0001;
               end
`endif
            end
         end
      end
   end

   assign wen        = r_wen;
   assign wdata      = r_wdata;
   assign done       = r_done;
   assign drop_err   = r_drop_err;
   assign bytes_left = r_bytes_left;
   assign busy       = (r_state == ST_ARMED) || (r_state == ST_CAPTURE) || (r_state == ST_FLUSH);
`ifdef FIFO_PACKER_STATS_EN
   assign drop_count = r_drop_count;
`endif

endmodule : fifo_byte_packer
